ex_div_unit: RTL and testbench

- Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the EX stage beside the combinational ALU. It receives the same operation code and operands (in1_select/in2_select).
- Its result is muxed with ALU_result before the EX/MEM register.
- The pipeline stalls on busy until the result is consumed.

---
 rtl/div_if.sv | 25 ++
 rtl/ex_div_unit.sv | 147 ++++++++++++++
 tb/tb_ex_div_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Request/result bundle between the EX stage and the multi-cycle divider.
// The pipeline side uses the master modport and the divider uses the slave modport.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       ALU_operation;
  logic [WIDTH-1:0] in1_select;
  logic [WIDTH-1:0] in2_select;
  logic             flush;
  logic             result_ready;
  logic             busy;
  logic             div_valid;
  logic [WIDTH-1:0] div_result;

  modport master (
    output start, ALU_operation, in1_select, in2_select, flush, result_ready,
    input  busy, div_valid, div_result
  );

  modport slave (
    input  start, ALU_operation, in1_select, in2_select, flush, result_ready,
    output busy, div_valid, div_result
  );
endinterface

// File: rtl/ex_div_unit.sv
// Restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN skips the iterations when |divisor| > |dividend|.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] result_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             signed_reg;
  logic             is_rem_reg;
  logic             neg_a_reg;
  logic             neg_b_reg;
  logic             busy_reg;
  logic             valid_reg;

  logic             op_legal;
  logic             op_signed;
  logic             op_rem;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Opcodes 01_01xx: bit 0 clear means signed, bit 1 set means remainder.
  assign op_legal  = (bus.ALU_operation[5:2] == 4'b0101);
  assign op_signed = ~bus.ALU_operation[0];
  assign op_rem    = bus.ALU_operation[1];
  assign a_neg     = op_signed & bus.in1_select[WIDTH-1];
  assign b_neg     = op_signed & bus.in2_select[WIDTH-1];
  assign a_mag     = a_neg ? -bus.in1_select : bus.in1_select;
  assign b_mag     = b_neg ? -bus.in2_select : bus.in2_select;
  assign div_zero  = (bus.in2_select == '0);
  assign overflow  = op_signed && (bus.in1_select == MOST_NEG) && (bus.in2_select == '1);

  // The quotient register starts as the dividend; its MSB feeds the partial remainder.
  assign shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_reg};

  assign q_fix = (signed_reg && (neg_a_reg != neg_b_reg)) ? -quo_reg : quo_reg;
  assign r_fix = (signed_reg && neg_a_reg) ? -rem_reg : rem_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      quo_reg    <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      signed_reg <= 1'b0;
      is_rem_reg <= 1'b0;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else if (bus.flush) begin
      state_reg  <= IDLE;
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start && op_legal) begin
            signed_reg <= op_signed;
            is_rem_reg <= op_rem;
            neg_a_reg  <= a_neg;
            neg_b_reg  <= b_neg;
            dvs_reg    <= b_mag;
            cnt_reg    <= CNT_LAST;
            busy_reg   <= 1'b1;
            if (div_zero) begin
              result_reg <= op_rem ? bus.in1_select : '1;
              valid_reg  <= 1'b1;
              state_reg  <= DONE;
            end else if (overflow) begin
              result_reg <= op_rem ? '0 : MOST_NEG;
              valid_reg  <= 1'b1;
              state_reg  <= DONE;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (b_mag > a_mag) begin
              quo_reg   <= '0;
              rem_reg   <= a_mag;
              state_reg <= FIX;
            end
`endif
            else begin
              quo_reg   <= a_mag;
              rem_reg   <= '0;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          if (!diff[WIDTH]) begin
            rem_reg <= diff[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= shifted[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == '0) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          result_reg <= is_rem_reg ? r_fix : q_fix;
          valid_reg  <= 1'b1;
          state_reg  <= DONE;
        end
        DONE: begin
          if (bus.result_ready) begin
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.div_valid  = valid_reg;
  assign bus.div_result = result_reg;
endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: arithmetic reference model plus a per-cycle compare process.
// Build with or without DIV_EARLY_OUT_EN; the expected latency follows the macro.
module tb_ex_div_unit;
  localparam int W = 32;
  localparam logic [5:0] DIVOP  = 6'b01_0100;
  localparam logic [5:0] DIVUOP = 6'b01_0101;
  localparam logic [5:0] REMOP  = 6'b01_0110;
  localparam logic [5:0] REMUOP = 6'b01_0111;

  logic clk = 1'b0;
  logic rst = 1'b0;

  div_if #(.WIDTH(W)) bus ();

  ex_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit          armed = 1'b0;
  bit          in_flight = 1'b0;
  bit          seen_valid = 1'b0;
  logic [31:0] exp_res = '0;
  logic [31:0] obs_res = '0;
  int          exp_lat = 0;
  int          obs_lat = 0;
  int          k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V division semantics in plain integer arithmetic.
  function automatic logic [31:0] model_res(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa;
    int sb;
    bit ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      DIVUOP: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REMUOP: return (b == 0) ? a : a % b;
      DIVOP: begin
        if (b == 0) return 32'hFFFF_FFFF;
        else if (ovf) return 32'h8000_0000;
        else return 32'(sa / sb);
      end
      default: begin
        if (b == 0) return a;
        else if (ovf) return 32'h0;
        else return 32'(sa % sb);
      end
    endcase
  endfunction

  // Number of clock edges after the accepting edge before valid is seen.
  function automatic int model_lat(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    bit     sgn;
    longint ma;
    longint mb;
    sgn = (op == DIVOP) || (op == REMOP);
    if (b == 0) return 0;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    ma = sgn ? longint'($signed(a)) : longint'(a);
    mb = sgn ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
    if (mb > ma) return 1;
`endif
    return W + 1;
  endfunction

  // Compare process: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (armed) begin
      armed      = 1'b0;
      in_flight  = 1'b1;
      k          = 0;
      seen_valid = 1'b0;
    end else if (in_flight) begin
      k++;
    end
    if (in_flight) begin
      chk("busy_in_flight", 32'(bus.busy), 32'd1);
      if (seen_valid || bus.div_valid) begin
        if (!seen_valid) begin
          chk("latency", 32'(k), 32'(exp_lat));
          obs_lat    = k;
          seen_valid = 1'b1;
        end
        chk("valid_held", 32'(bus.div_valid), 32'd1);
        chk("result", bus.div_result, exp_res);
        obs_res = bus.div_result;
      end
    end
  end

  // Called at a negedge with the divider idle; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_res           = model_res(op, a, b);
    exp_lat           = model_lat(op, a, b);
    bus.ALU_operation = op;
    bus.in1_select    = a;
    bus.in2_select    = b;
    bus.start         = 1'b1;
    seen_valid        = 1'b0;
    armed             = 1'b1;
    @(negedge clk);
    bus.start         = 1'b0;
    bus.in1_select    = $urandom;
    bus.in2_select    = $urandom;
    bus.ALU_operation = 6'($urandom);
  endtask

  // hold < 0: result_ready high from the start; otherwise hold cycles in DONE before accepting.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit pin, input logic [31:0] lit);
    int t;
    if (pin) chk("model_pin", model_res(op, a, b), lit);
    bus.result_ready = (hold < 0);
    start_op(op, a, b);
    t = 0;
    while (!seen_valid && t < 100) begin
      bus.start = 1'($urandom);
      @(negedge clk);
      t++;
    end
    if (!seen_valid) begin
      tests++;
      fails++;
      $display("FAIL valid_timeout: no div_valid within %0d cycles, expected after %0d", t, exp_lat);
    end
    for (int i = 0; i < hold; i++) begin
      bus.start = 1'($urandom);
      @(negedge clk);
    end
    bus.start        = 1'b0;
    bus.result_ready = 1'b1;
    in_flight        = 1'b0;
    @(negedge clk);
    bus.result_ready = 1'b0;
    chk("release_busy", 32'(bus.busy), 32'd0);
    chk("release_valid", 32'(bus.div_valid), 32'd0);
    $display("[TB] op=%b a=%08h b=%08h result=%08h expected=%08h latency=%0d", op, a, b,
             obs_res, exp_res, obs_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    bus.start         = 1'b0;
    bus.ALU_operation = '0;
    bus.in1_select    = '0;
    bus.in2_select    = '0;
    bus.flush         = 1'b0;
    bus.result_ready  = 1'b0;
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_valid", 32'(bus.div_valid), 32'd0);
    chk("reset_result", bus.div_result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(DIVUOP, 32'd100, 32'd7, 0, 1'b1, 32'd14);
    run_op(REMUOP, 32'd100, 32'd7, -1, 1'b1, 32'd2);
    run_op(DIVOP, 32'hFFFF_FF9C, 32'd7, 1, 1'b1, 32'hFFFF_FFF2);
    run_op(REMOP, 32'hFFFF_FF9C, 32'd7, 0, 1'b1, 32'hFFFF_FFFE);
    run_op(REMOP, 32'd100, 32'hFFFF_FFF9, 0, 1'b1, 32'd2);
    run_op(DIVOP, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 1'b1, 32'd14);
    run_op(DIVUOP, 32'd5, 32'd0, 0, 1'b1, 32'hFFFF_FFFF);
    run_op(REMOP, 32'd5, 32'd0, -1, 1'b1, 32'd5);
    run_op(DIVOP, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h8000_0000);
    run_op(REMOP, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b1, 32'd0);
    run_op(DIVUOP, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'd0);
    run_op(DIVUOP, 32'hFFFF_FFFF, 32'd1, 0, 1'b1, 32'hFFFF_FFFF);
    run_op(DIVUOP, 32'd3, 32'd10, 0, 1'b1, 32'd0);
    run_op(REMUOP, 32'd3, 32'd10, -1, 1'b1, 32'd3);
    run_op(DIVUOP, 32'd100, 32'd7, 10, 1'b1, 32'd14);
    run_op(REMUOP, 32'd9, 32'd4, 0, 1'b1, 32'd1);

    // Flush in the middle of an iteration, then a clean operation.
    start_op(DIVUOP, 32'h1234_5678, 32'd19);
    repeat (14) @(negedge clk);
    bus.flush = 1'b1;
    in_flight = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_valid", 32'(bus.div_valid), 32'd0);
    run_op(DIVUOP, 32'd9, 32'd3, 0, 1'b1, 32'd3);

    // Flush wins over start in IDLE, even for a request that would finish at once.
    bus.flush         = 1'b1;
    bus.start         = 1'b1;
    bus.ALU_operation = DIVUOP;
    bus.in1_select    = 32'd5;
    bus.in2_select    = 32'd0;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    chk("flush_start_busy", 32'(bus.busy), 32'd0);
    chk("flush_start_valid", 32'(bus.div_valid), 32'd0);

    // An illegal opcode is not accepted.
    bus.start         = 1'b1;
    bus.ALU_operation = 6'b00_0000;
    @(negedge clk);
    bus.start = 1'b0;
    chk("illegal_busy", 32'(bus.busy), 32'd0);
    chk("illegal_valid", 32'(bus.div_valid), 32'd0);

    // Asynchronous reset in the middle of an iteration.
    start_op(DIVOP, 32'h7654_3210, 32'hFFFF_FFFD);
    repeat (9) @(negedge clk);
    in_flight = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_valid", 32'(bus.div_valid), 32'd0);
    chk("async_rst_result", bus.div_result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(REMOP, 32'hFFFF_FF9C, 32'd7, 0, 1'b1, 32'hFFFF_FFFE);

    for (int n = 0; n < 200; n++) begin
      op  = {4'b0101, 2'($urandom)};
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); end
        3: b = 32'($signed(5'($urandom)));
        4: begin a = 32'($signed(8'($urandom))); b = 32'($signed(6'($urandom))); end
        default: ;
      endcase
      run_op(op, a, b, $urandom_range(0, 4) - 1, 1'b0, 32'd0);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
